// File: rtl/clk_enable_sequencer.sv
// Single-clock enable/reset sequencer: per-channel one-cycle ce strobes and staggered
// synchronous reset releases, driven by an IDLE/RST_HOLD/RELEASE/RUN/DRAIN state machine.
module clk_enable_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 8,
  parameter int RST_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [DIV_W-1:0]          cfg_phase,
  input  logic                      start,
  input  logic                      stop,
  output logic                      busy,
  output logic [NUM_CH-1:0]         ce,
  output logic [NUM_CH-1:0]         ch_rst_n
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int SEQ_MAX = (RST_CYC > NUM_CH) ? RST_CYC : NUM_CH;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  typedef enum logic [2:0] {IDLE, RST_HOLD, RELEASE, RUN, DRAIN} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [SEQ_W-1:0]   r_seqCnt;
  logic [SEQ_W-1:0]   w_nextSeq;
  logic [DIV_W-1:0]   r_div      [NUM_CH];
  logic [DIV_W-1:0]   r_phase    [NUM_CH];
  logic [DIV_W-1:0]   r_chCnt    [NUM_CH];
  logic [DIV_W-1:0]   w_startCnt [NUM_CH];
  logic [NUM_CH-1:0]  r_ce;
  logic [NUM_CH-1:0]  r_chRstN;
  logic [NUM_CH-1:0]  r_done;
  logic [NUM_CH-1:0]  w_en;
  logic [NUM_CH-1:0]  w_hit;
  logic [NUM_CH-1:0]  w_relBit;
  logic [DIV_W-1:0]   w_cfgPhase;
  logic               w_cfgWrite;

  assign cfg_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign ce         = r_ce;
  assign ch_rst_n   = r_chRstN;
  assign w_cfgWrite = cfg_valid && cfg_ready;

  // Phase is clamped into [0, div-1] so the first strobe always lands inside one period.
  always_comb begin
    w_cfgPhase = '0;
    if (cfg_div != '0) begin
      w_cfgPhase = (cfg_phase > (cfg_div - DIV_W'(1))) ? (cfg_div - DIV_W'(1)) : cfg_phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_seqCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_seqCnt <= w_nextSeq;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextSeq   = r_seqCnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = RST_HOLD;
          w_nextSeq   = '0;
        end
      end
      RST_HOLD: begin
        if (stop) begin
          w_nextState = IDLE;
        end else if (r_seqCnt == SEQ_W'(RST_CYC - 1)) begin
          w_nextState = RELEASE;
          w_nextSeq   = '0;
        end else begin
          w_nextSeq = r_seqCnt + SEQ_W'(1);
        end
      end
      RELEASE: begin
        if (stop) begin
          w_nextState = IDLE;
        end else if (r_seqCnt == SEQ_W'(NUM_CH - 1)) begin
          w_nextState = RUN;
          w_nextSeq   = '0;
        end else begin
          w_nextSeq = r_seqCnt + SEQ_W'(1);
        end
      end
      RUN: begin
        if (stop) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (&r_done) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Counter holds the value for the cycle about to be registered: zero means a strobe,
  // and it is preloaded to (div - phase) mod div while RELEASE runs.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_en[i]       = (r_div[i] != '0);
      w_hit[i]      = w_en[i] && (r_chCnt[i] == '0);
      w_startCnt[i] = (r_phase[i] == '0) ? '0 : (r_div[i] - r_phase[i]);
      w_relBit[i]   = w_en[i] && (w_nextSeq == SEQ_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= '0;
        r_phase[i] <= '0;
        r_chCnt[i] <= '0;
      end
      r_ce     <= '0;
      r_chRstN <= '0;
      r_done   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cfgWrite && (cfg_ch == CH_W'(i))) begin
          r_div[i]   <= cfg_div;
          r_phase[i] <= w_cfgPhase;
        end
        if (w_nextState == RELEASE) begin
          r_chCnt[i] <= w_startCnt[i];
        end else if ((w_nextState == RUN) || (w_nextState == DRAIN)) begin
          r_chCnt[i] <= (r_chCnt[i] == (r_div[i] - DIV_W'(1))) ? '0 : (r_chCnt[i] + DIV_W'(1));
        end
      end
      // Outputs follow the state being entered so they change in step with it.
      case (w_nextState)
        RELEASE: begin
          r_chRstN <= r_chRstN | w_relBit;
          r_ce     <= '0;
          r_done   <= '0;
        end
        RUN: begin
          r_ce   <= w_hit;
          r_done <= '0;
        end
        DRAIN: begin
          r_ce   <= w_hit & ~r_done;
          r_done <= r_done | w_hit | ~w_en;
        end
        default: begin
          r_ce     <= '0;
          r_chRstN <= '0;
          r_done   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_enable_sequencer.sv
// Directed self-checking bench for clk_enable_sequencer: reset, staggered release, strobe
// patterns, drain, abort, config gating, disable-by-zero and asynchronous reset mid-run.
module tb_clk_enable_sequencer;

  localparam int NUM_CH  = 4;
  localparam int DIV_W   = 8;
  localparam int RST_CYC = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              busy;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] ch_rst_n;

  int checks = 0;
  int failures = 0;
  int mDiv [NUM_CH];
  int mPh  [NUM_CH];

  clk_enable_sequencer #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .RST_CYC (RST_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .ce        (ce),
    .ch_rst_n  (ch_rst_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iStart, input logic iStop);
    start = iStart;
    stop  = iStop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic writeConfig(input int ch, input int div, input int ph);
    checkOutput("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = DIV_W'(div);
    cfg_phase = DIV_W'(ph);
    tick();
    cfg_valid = 1'b0;
    mDiv[ch] = div;
    mPh[ch]  = (div == 0) ? 0 : ((ph > div - 1) ? div - 1 : ph);
  endtask

  function automatic bit chHit(input int i, input int k);
    if (mDiv[i] == 0 || k < mPh[i]) return 1'b0;
    return ((k - mPh[i]) % mDiv[i]) == 0;
  endfunction

  function automatic logic [NUM_CH-1:0] expCe(input int k);
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = chHit(i, k);
    return v;
  endfunction

  // Full run from IDLE: hold, release, RUN up to stopAt (stop driven in that cycle), drain, idle.
  task automatic runAndCheck(input int stopAt, input bit tryCfg);
    logic [NUM_CH-1:0] expRst;
    logic [NUM_CH-1:0] expDrain;
    int last [NUM_CH];
    int endCyc;
    bit found;
    applyStimulus(1'b1, 1'b0);
    for (int h = 0; h < RST_CYC; h++) begin
      checkOutput("hold_rst", 32'(ch_rst_n), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
      checkOutput("hold_ce", 32'(ce), 32'd0);
      tick();
    end
    expRst = '0;
    for (int r = 0; r < NUM_CH; r++) begin
      if (mDiv[r] != 0) expRst[r] = 1'b1;
      checkOutput("release_rst", 32'(ch_rst_n), 32'(expRst));
      checkOutput("release_ce", 32'(ce), 32'd0);
      tick();
    end
    for (int k = 0; k <= stopAt; k++) begin
      checkOutput("run_ce", 32'(ce), 32'(expCe(k)));
      checkOutput("run_rst", 32'(ch_rst_n), 32'(expRst));
      if (tryCfg && k == 1) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 8'd7;
        cfg_phase = 8'd3;
        checkOutput("run_cfg_ready", 32'(cfg_ready), 32'd0);
      end
      applyStimulus(1'b0, k == stopAt);
      cfg_valid = 1'b0;
    end
    endCyc = stopAt + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      last[i] = -1;
      found = 1'b0;
      if (mDiv[i] != 0) begin
        for (int l = stopAt + 1; l <= stopAt + 256; l++) begin
          if (!found && chHit(i, l)) begin
            last[i] = l;
            found = 1'b1;
          end
        end
      end
      if (last[i] > endCyc) endCyc = last[i];
    end
    endCyc = endCyc + 1;
    for (int k = stopAt + 1; k < endCyc; k++) begin
      for (int i = 0; i < NUM_CH; i++) expDrain[i] = (last[i] == k);
      checkOutput("drain_ce", 32'(ce), 32'(expDrain));
      checkOutput("drain_busy", 32'(busy), 32'd1);
      checkOutput("drain_rst", 32'(ch_rst_n), 32'(expRst));
      tick();
    end
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_rst", 32'(ch_rst_n), 32'd0);
    checkOutput("end_ce", 32'(ce), 32'd0);
    checkOutput("end_ready", 32'(cfg_ready), 32'd1);
    repeat (2) begin
      tick();
      checkOutput("post_ce", 32'(ce), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      mDiv[i] = 0;
      mPh[i]  = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("inreset_ce", 32'(ce), 32'd0);
    checkOutput("inreset_rst", 32'(ch_rst_n), 32'd0);
    checkOutput("inreset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("reset_ce", 32'(ce), 32'd0);
    checkOutput("reset_rst", 32'(ch_rst_n), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(cfg_ready), 32'd1);

    writeConfig(0, 1, 0);
    writeConfig(1, 4, 2);
    writeConfig(2, 3, 5);
    writeConfig(3, 0, 0);

    // First run: stop at RUN cycle 7, drain ends after ce[1] at cycle 10.
    runAndCheck(7, 1'b0);
    // Rerun with a rejected config write mid-run; pattern must be unchanged.
    runAndCheck(11, 1'b1);

    // Abort during RST_HOLD cycle 2.
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    checkOutput("abort_hold_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_hold_idle", 32'(busy), 32'd0);
    checkOutput("abort_hold_rst", 32'(ch_rst_n), 32'd0);
    repeat (3) begin
      checkOutput("abort_hold_ce", 32'(ce), 32'd0);
      tick();
    end

    // Abort during RELEASE cycle 2: bits 0..2 already high, all drop next cycle.
    applyStimulus(1'b1, 1'b0);
    repeat (RST_CYC + 2) tick();
    checkOutput("abort_rel_rst_before", 32'(ch_rst_n), 32'h7);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_rel_rst", 32'(ch_rst_n), 32'd0);
    checkOutput("abort_rel_busy", 32'(busy), 32'd0);
    checkOutput("abort_rel_ce", 32'(ce), 32'd0);

    // Disable ch1 with div=0, enable ch3 with div=2 phase=1.
    writeConfig(1, 0, 9);
    writeConfig(3, 2, 1);
    runAndCheck(5, 1'b0);

    // Async reset in RUN cycle 5, between clock edges.
    applyStimulus(1'b1, 1'b0);
    repeat (RST_CYC + NUM_CH + 5) tick();
    checkOutput("prereset_ce", 32'(ce), 32'hD);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_ce", 32'(ce), 32'd0);
    checkOutput("async_rst", 32'(ch_rst_n), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_ready", 32'(cfg_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_CH; i++) begin
      mDiv[i] = 0;
      mPh[i]  = 0;
    end
    runAndCheck(3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
